// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants and writeback-class encoding for the WB stage.
package mips_isa_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  // SPECIAL funct codes that matter to writeback
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_SYSC  = 6'h0C;
  localparam logic [5:0] FN_BRK   = 6'h0D;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Link register used by jal
  localparam logic [4:0] REG_RA = 5'd31;

  // What a retiring instruction writes back
  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_RTYPE,
    CLS_JALR,
    CLS_IALU,
    CLS_LOAD,
    CLS_JAL
  } wb_class_e;

  // SPECIAL functs that never write a GPR (jumps, traps, HI/LO writers)
  function automatic logic is_nonwriting_funct(input logic [5:0] funct);
    case (funct)
      FN_JR, FN_SYSC, FN_BRK, FN_MTHI, FN_MTLO,
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_nonwriting_funct = 1'b1;
      default:                            is_nonwriting_funct = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian byte/halfword extraction with sign/zero extension for loads.
module load_align
  import mips_isa_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword; offset 0 is the most significant lane,
  // and address bit 0 is ignored for halfwords (no alignment trap here).
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[15:0] : word[31:16];
  end

  // Extend the selected lane according to the load flavour.
  always_comb begin
    case (op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB writeback decode plus 32x32 GPR file with two combinational read ports.
// Optional same-cycle write-through to the read ports: define WB_BYPASS_EN.
module wb_regfile
  import mips_isa_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] MEM_WB_PCPlusBy4,
  input  logic [31:0] MEM_WB_Instr,
  input  logic [31:0] MEM_WB_Mult_Mux_o,
  input  logic [31:0] MEM_WB_dataMem_o,
  input  logic [4:0]  RdAddr1,
  input  logic [4:0]  RdAddr2,
  output logic [31:0] RdData1,
  output logic [31:0] RdData2,
  output logic        WB_We,
  output logic [4:0]  WB_Dst,
  output logic [31:0] WB_Data
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  wb_class_e   wb_class;
  logic [31:0] load_data;
  logic [31:0] rf_row [32];

  assign opcode = MEM_WB_Instr[31:26];
  assign funct  = MEM_WB_Instr[5:0];

  load_align u_load_align (
    .op      (opcode),
    .addr_lo (MEM_WB_Mult_Mux_o[1:0]),
    .word    (MEM_WB_dataMem_o),
    .data    (load_data)
  );

  // Classify the retiring instruction; an all-zero word is a bubble.
  always_comb begin
    wb_class = CLS_NONE;
    case (opcode)
      OP_SPECIAL: begin
        if (MEM_WB_Instr != 32'h0) begin
          if (funct == FN_JALR)                wb_class = CLS_JALR;
          else if (!is_nonwriting_funct(funct)) wb_class = CLS_RTYPE;
        end
      end
      OP_JAL:                           wb_class = CLS_JAL;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: wb_class = CLS_LOAD;
      default: if (opcode[5:3] == 3'b001) wb_class = CLS_IALU;
    endcase
  end

  // Destination/data per class; register 0 is never a real write target.
  always_comb begin
    WB_Dst  = 5'd0;
    WB_Data = 32'h0;
    case (wb_class)
      CLS_RTYPE: begin WB_Dst = MEM_WB_Instr[15:11]; WB_Data = MEM_WB_Mult_Mux_o; end
      CLS_JALR:  begin WB_Dst = MEM_WB_Instr[15:11]; WB_Data = MEM_WB_PCPlusBy4;  end
      CLS_IALU:  begin WB_Dst = MEM_WB_Instr[20:16]; WB_Data = MEM_WB_Mult_Mux_o; end
      CLS_LOAD:  begin WB_Dst = MEM_WB_Instr[20:16]; WB_Data = load_data;         end
      CLS_JAL:   begin WB_Dst = REG_RA;              WB_Data = MEM_WB_PCPlusBy4;  end
      default:   ;
    endcase
    WB_We = (wb_class != CLS_NONE) && (WB_Dst != 5'd0);
  end

  assign rf_row[0] = 32'h0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] q_reg;
      // One GPR: cleared by reset, loaded when it is the writeback target.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)
          q_reg <= 32'h0;
        else if (WB_We && (WB_Dst == 5'(gi)))
          q_reg <= WB_Data;
      end
      assign rf_row[gi] = q_reg;
    end
  endgenerate

  // Read port 1: array value, optional write-through, forced 0 during reset.
  always_comb begin
    RdData1 = rf_row[RdAddr1];
`ifdef WB_BYPASS_EN
    if (WB_We && (RdAddr1 == WB_Dst)) RdData1 = WB_Data;
`endif
    if (RST) RdData1 = 32'h0;
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    RdData2 = rf_row[RdAddr2];
`ifdef WB_BYPASS_EN
    if (WB_We && (RdAddr2 == WB_Dst)) RdData2 = WB_Data;
`endif
    if (RST) RdData2 = 32'h0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a behavioural writeback/register model.
module tb_wb_regfile;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pc4 = '0, instr = '0, alu = '0, mem = '0;
  logic [4:0]  ra1 = '0, ra2 = '0;
  logic [31:0] rd1, rd2, wb_data;
  logic        wb_we;
  logic [4:0]  wb_dst;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_rf [32];

  wb_regfile dut (
    .CLK(CLK), .RST(RST),
    .MEM_WB_PCPlusBy4(pc4), .MEM_WB_Instr(instr),
    .MEM_WB_Mult_Mux_o(alu), .MEM_WB_dataMem_o(mem),
    .RdAddr1(ra1), .RdAddr2(ra2),
    .RdData1(rd1), .RdData2(rd2),
    .WB_We(wb_we), .WB_Dst(wb_dst), .WB_Data(wb_data)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
    r_type = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
    i_type = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // What the architecture says this instruction writes back.
  function automatic void model_wb(output logic we, output logic [4:0] dst, output logic [31:0] data);
    int op, fn, sh, width;
    logic sgn;
    logic [31:0] v, mask;
    op = int'(instr[31:26]);
    fn = int'(instr[5:0]);
    we = 1'b0; dst = 5'd0; data = 32'h0;
    if (op == 0) begin
      if (instr == 32'h0 || fn inside {8, 12, 13, 17, 19, 24, 25, 26, 27}) we = 1'b0;
      else begin
        we = 1'b1; dst = instr[15:11];
        data = (fn == 9) ? pc4 : alu;
      end
    end else if (op == 3) begin
      we = 1'b1; dst = 5'd31; data = pc4;
    end else if (op >= 8 && op <= 15) begin
      we = 1'b1; dst = instr[20:16]; data = alu;
    end else if (op inside {32, 33, 35, 36, 37}) begin
      we = 1'b1; dst = instr[20:16];
      width = (op == 35) ? 32 : (op == 33 || op == 37) ? 16 : 8;
      sgn   = (op == 32 || op == 33);
      if (width == 8)       sh = 8 * (3 - int'(alu[1:0]));
      else if (width == 16) sh = alu[1] ? 0 : 16;
      else                  sh = 0;
      mask = (width == 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
      v = (mem >> sh) & mask;
      if (sgn && v[width-1]) v = v | ~mask;
      data = v;
    end
    if (dst == 5'd0) we = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic we; logic [4:0] d; logic [31:0] v;
    model_wb(we, d, v);
    if (RST) return 32'h0;
`ifdef WB_BYPASS_EN
    if (we && a == d) return v;
`endif
    return model_rf[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model register file: cleared by reset, written on clock edges outside reset.
  initial for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
  always @(posedge CLK or posedge RST) begin
    logic we; logic [4:0] d; logic [31:0] v;
    if (RST) begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    end else begin
      model_wb(we, d, v);
      if (we) model_rf[d] = v;
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge CLK) begin
    logic we; logic [4:0] d; logic [31:0] v;
    model_wb(we, d, v);
    check("cyc_we", {31'h0, wb_we}, {31'h0, we});
    if (we) begin
      check("cyc_dst", {27'h0, wb_dst}, {27'h0, d});
      check("cyc_data", wb_data, v);
    end
    check("cyc_rd1", rd1, model_read(ra1));
    check("cyc_rd2", rd2, model_read(ra2));
    $display("t=%0t instr=%h we=%b dst=%0d data=%h rd1[%0d]=%h rd2[%0d]=%h",
             $time, instr, wb_we, wb_dst, wb_data, ra1, rd1, ra2, rd2);
  end

  task automatic step(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] m, input int a1, input int a2);
    @(posedge CLK); #1;
    instr = i; pc4 = p; alu = a; mem = m; ra1 = 5'(a1); ra2 = 5'(a2);
  endtask

  task automatic settle();
    @(negedge CLK); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1 ra1 = 5'd5; ra2 = 5'd31;
    settle();
    check("rst_rd1", rd1, 32'h0);
    check("rst_rd2", rd2, 32'h0);
    @(negedge CLK); #2 RST = 1'b0;

    // Loads
    step(i_type(6'h20, 0, 5, 1), 0, 32'h0000_1001, 32'h12F4_5678, 0, 0);
    step(32'h0, 0, 0, 0, 5, 0); settle();
    check("lb_r5", rd1, 32'hFFFF_FFF4);
    step(i_type(6'h24, 0, 5, 1), 0, 32'h0000_1001, 32'h12F4_5678, 0, 0);
    step(32'h0, 0, 0, 0, 5, 0); settle();
    check("lbu_r5", rd1, 32'h0000_00F4);
    step(i_type(6'h21, 0, 7, 2), 0, 32'h0000_2002, 32'h8765_ABCD, 0, 0);
    step(i_type(6'h25, 0, 9, 1), 0, 32'h0000_2001, 32'h8765_ABCD, 0, 0);
    step(i_type(6'h20, 0, 10, 3), 0, 32'h0000_3003, 32'h0000_0080, 0, 0);
    step(i_type(6'h24, 0, 11, 0), 0, 32'h0000_3000, 32'hA100_0000, 0, 0);
    step(i_type(6'h23, 0, 6, 0), 0, 32'h0000_4000, 32'hCAFE_F00D, 7, 9);
    settle();
    check("lh_r7", rd1, 32'hFFFF_ABCD);
    check("lhu_r9", rd2, 32'h0000_8765);
    step(32'h0, 0, 0, 0, 10, 11); settle();
    check("lb_off3_r10", rd1, 32'hFFFF_FF80);
    check("lbu_off0_r11", rd2, 32'h0000_00A1);

    // jal / jalr
    step({6'h03, 26'h0100004}, 32'h0040_0010, 32'h1234_5678, 0, 6, 0); settle();
    check("jal_dst", {27'h0, wb_dst}, 32'd31);
    check("lw_r6", rd1, 32'hCAFE_F00D);
    step(r_type(4, 0, 12, 9), 32'h0040_0020, 32'h9999_9999, 0, 31, 0); settle();
    check("jal_r31", rd1, 32'h0040_0010);
    step(32'h0, 0, 0, 0, 12, 0); settle();
    check("jalr_r12", rd1, 32'h0040_0020);

    // add to r0 and non-writing instructions
    step(r_type(1, 2, 0, 32), 0, 32'hDEAD_BEEF, 0, 0, 0); settle();
    check("add_r0_we", {31'h0, wb_we}, 32'h0);
    check("add_r0_rd", rd1, 32'h0);
    step(r_type(1, 2, 13, 8), 0, 32'h1111_1111, 0, 13, 0);
    step(r_type(1, 2, 14, 24), 0, 32'h2222_2222, 0, 14, 0);
    step(i_type(6'h2B, 0, 15, 0), 0, 32'h3333_3333, 0, 15, 0);
    step(r_type(1, 2, 16, 33), 0, 32'h4444_4444, 0, 13, 14); settle();
    check("jr_no_write", rd1, 32'h0);
    check("mult_no_write", rd2, 32'h0);

    // Same-cycle read during write
    step(i_type(6'h0D, 0, 8, 17), 0, 32'h0000_0011, 0, 15, 16);
    settle();
    check("sw_no_write", rd1, 32'h0);
    check("addu_r16", rd2, 32'h4444_4444);
    step(i_type(6'h08, 0, 8, 85), 0, 32'h0000_0055, 0, 8, 0); settle();
`ifdef WB_BYPASS_EN
    check("bypass_r8", rd1, 32'h0000_0055);
`else
    check("old_r8", rd1, 32'h0000_0011);
`endif
    step(32'h0, 0, 0, 0, 8, 0); settle();
    check("next_r8", rd1, 32'h0000_0055);

    // Reset between edges
    step(i_type(6'h09, 0, 3, 7), 0, 32'h0000_0007, 0, 0, 0);
    step(i_type(6'h08, 0, 4, 153), 0, 32'h0000_0099, 0, 3, 4); settle();
    check("r3_before_rst", rd1, 32'h0000_0007);
    #1 RST = 1'b1;
    #1 check("r3_in_rst", rd1, 32'h0);
    @(negedge CLK); #2 RST = 1'b0;
    #1 check("r4_dropped", rd2, 32'h0);
    check("r3_cleared", rd1, 32'h0);
    step(i_type(6'h09, 0, 3, 34), 0, 32'h0000_0022, 0, 0, 0);
    step(32'h0, 0, 0, 0, 3, 8); settle();
    check("resume_r3", rd1, 32'h0000_0022);
    check("r8_cleared", rd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have a single clock, CLK (input, 1): all state updates on its rising edge.
REQ-002 SHALL have RST (input, 1): asynchronous, active-high reset.
REQ-003 SHALL have MEM_WB_PCPlusBy4 (input, 32): the PC+4 of the retiring instruction.
REQ-004 SHALL have MEM_WB_Instr (input, 32): the retiring instruction word.
REQ-005 SHALL have MEM_WB_Mult_Mux_o (input, 32): the ALU result, which is also the load address.
REQ-006 SHALL have MEM_WB_dataMem_o (input, 32): the raw word read from data memory.
REQ-007 SHALL have RdAddr1 and RdAddr2 (input, 5 each): the ID-stage read addresses.
REQ-008 SHALL have RdData1 and RdData2 (output, 32 each): the combinational read data.
REQ-009 SHALL have WB_We (output, 1), WB_Dst (output, 5) and WB_Data (output, 32): the current-cycle writeback, exported for forwarding.

Function
REQ-010 SHALL decode opcode (Instr[31:26]) and funct (Instr[5:0]) combinationally.
REQ-011 SHALL select destination and data by instruction class:
- R-type (op 0x00): rd, ALU result.
- jalr (op 0x00, funct 0x09): rd, PC+4.
- I-type ALU (op 0x08-0x0F): rt, ALU result.
- Load (op 0x20/0x21/0x23/0x24/0x25): rt, extracted load data.
- jal (op 0x03): register 31, PC+4.
REQ-012 SHALL treat R-type funct 0x08, 0x0C, 0x0D, 0x11, 0x13 and 0x18-0x1B, and every other opcode, as non-writing (WB_We=0).
REQ-013 SHALL write PC+4 exactly as presented for jal/jalr, with no +8 delay-slot correction.
REQ-014 SHALL extract load data big-endian using address bits [1:0] of MEM_WB_Mult_Mux_o:
- lb/lbu: offset 0 selects bits 31:24, offset 3 selects bits 7:0.
- lh/lhu: address bit 1 = 0 selects bits 31:16, = 1 selects bits 15:0.
- lw: full word.
REQ-015 SHALL sign-extend lb/lh and zero-extend lbu/lhu to 32 bits.
REQ-016 SHALL ignore address bit 0 for halfwords, with no alignment exception.
REQ-017 SHALL force WB_We=0 when the destination is register 0; register 0 SHALL always read 0 and never be written.
REQ-018 SHALL hold a 32x32 register file and write WB_Data to WB_Dst on the rising CLK edge when WB_We=1, with 1-cycle write latency.
REQ-019 SHALL make read ports purely combinational from the array, plus the optional bypass of REQ-025.
REQ-020 SHALL treat a MEM_WB_Instr of all zeros (bubble/sll r0) as non-writing.

Reset
REQ-021 SHALL, while RST is high, asynchronously clear all 32 registers to 0 and block writes.
REQ-022 SHALL make RdData1/RdData2 read 0 while RST is high.
REQ-023 SHALL not commit a write whose clock edge coincides with RST being asserted.
REQ-024 SHALL resume normal operation on the first rising CLK edge after RST deasserts.

Configuration
REQ-025 SHALL, with WB_BYPASS_EN defined: when WB_We=1, RdAddrN==WB_Dst and WB_Dst!=0, drive RdDataN = WB_Data in the same cycle (write-through).
REQ-026 SHALL, without WB_BYPASS_EN: return only the array contents, with the new value visible the cycle after the write edge.

Structure
REQ-027 SHALL place the opcode/funct constants, the register-31 constant and the class encoding in a shared package, mips_isa_pkg.
REQ-028 SHALL implement load extraction as a combinational sub-module, load_align, instantiated once.

Verification
REQ-029 SHALL cover load extraction:
- Instr = lb r5 (op 0x20), Addr = 0x...1, Mem = 0x12F45678: r5 = 0xFFFFFFF4 next cycle.
- Same stimulus with lbu: r5 = 0x000000F4.
REQ-030 SHALL cover jal with PCPlusBy4 = 0x00400010: r31 = 0x00400010, WB_Dst = 31.
REQ-031 SHALL cover R-type add with rd = 0, result 0xDEADBEEF: WB_We = 0 and r0 still reads 0.
REQ-032 SHALL cover a same-cycle read of r8 during an addi write of 0x55 to r8:
- RdData1 = 0x55 with WB_BYPASS_EN.
- The old value without it, and 0x55 on the next cycle.
REQ-033 SHALL cover RST pulsed between CLK edges after writing r3 = 7: r3 reads 0 immediately, and a write coincident with RST is dropped.
